// File: rtl/debug_cmd_parser_if.sv
// Byte-stream input and command-output handshake between the serial receiver,
// the command parser and the debug sequencer.
interface debug_cmd_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  cmd;
  logic [31:0] arg;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        frame_err;
  logic        overrun;

  // The parser side consumes the byte stream and drives the command channel.
  modport master (
    input  rx_data, rx_valid, cmd_ready,
    output cmd, arg, cmd_valid, frame_err, overrun
  );

  modport slave (
    output rx_data, rx_valid, cmd_ready,
    input  cmd, arg, cmd_valid, frame_err, overrun
  );
endinterface

// File: rtl/debug_cmd_parser.sv
// Frames the raw receive byte stream into opcode/argument debug commands and
// injects the 8'hFF timeout pseudo-command after a long silence.
module debug_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_DIGITS     = 8
) (
  input  logic               clk,
  input  logic               rst,
  debug_cmd_parser_if.master bus
);

  typedef enum logic [1:0] {IDLE, ARG, HOLD} state_t;

  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [DW-1:0] DIG_MAX = DW'(MAX_DIGITS);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [39:0]   ARG_OPS = "ABOMr";

  state_t        state_reg;
  logic [7:0]    cmd_reg;
  logic [31:0]   arg_reg;
  logic          cmd_valid_reg;
  logic          frame_err_reg;
  logic          overrun_reg;
  logic [31:0]   acc_reg;
  logic [DW-1:0] dig_cnt_reg;
  logic [TW-1:0] to_cnt_reg;

  logic       is_hex;
  logic [3:0] nibble;
  logic       is_eol;
  logic       is_blank;
  logic       is_arg_op;
  logic [4:0] op_match;
  logic       to_hit;
  logic       open_frame;

  always_comb begin
    is_hex = 1'b1;
    nibble = 4'd0;
    if (bus.rx_data >= "0" && bus.rx_data <= "9") begin
      nibble = bus.rx_data[3:0];
    end else if ((bus.rx_data >= "A" && bus.rx_data <= "F") ||
                 (bus.rx_data >= "a" && bus.rx_data <= "f")) begin
      nibble = bus.rx_data[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_op
      assign op_match[gi] = (bus.rx_data == ARG_OPS[gi*8 +: 8]);
    end
    if (TIMEOUT_CYCLES > 0) begin : g_to
      assign to_hit = (to_cnt_reg == TO_LAST);
    end else begin : g_no_to
      assign to_hit = 1'b0;
    end
  endgenerate

  assign is_arg_op = |op_match;
  assign is_eol    = (bus.rx_data == 8'h0A) || (bus.rx_data == 8'h0D);
  assign is_blank  = is_eol || (bus.rx_data == 8'h20);

  // A byte that lands on the handshake cycle is treated exactly like one in IDLE.
  assign open_frame = bus.rx_valid && !is_blank &&
                      ((state_reg == IDLE) || (state_reg == HOLD && bus.cmd_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cmd_reg       <= 8'd0;
      arg_reg       <= 32'd0;
      cmd_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      acc_reg       <= 32'd0;
      dig_cnt_reg   <= '0;
      to_cnt_reg    <= '0;
    end else begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.rx_valid) begin
            to_cnt_reg <= '0;
          end else if (to_hit) begin
            to_cnt_reg    <= '0;
            cmd_reg       <= 8'hFF;
            arg_reg       <= 32'd0;
            cmd_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        ARG: begin
          if (bus.rx_valid) begin
            to_cnt_reg <= '0;
            if (is_hex) begin
              if (dig_cnt_reg == DIG_MAX) begin
                frame_err_reg <= 1'b1;
                state_reg     <= IDLE;
              end else begin
                acc_reg     <= {acc_reg[27:0], nibble};
                dig_cnt_reg <= dig_cnt_reg + 1'b1;
              end
            end else if (is_eol && dig_cnt_reg != '0) begin
              arg_reg       <= acc_reg;
              cmd_valid_reg <= 1'b1;
              state_reg     <= HOLD;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= IDLE;
            end
          end else if (to_hit) begin
            to_cnt_reg    <= '0;
            frame_err_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        HOLD: begin
          to_cnt_reg <= '0;
          if (bus.cmd_ready) begin
            cmd_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end else if (bus.rx_valid) begin
            overrun_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Later assignments override the per-state defaults above.
      if (open_frame) begin
        cmd_reg <= bus.rx_data;
        if (is_arg_op) begin
          acc_reg       <= 32'd0;
          dig_cnt_reg   <= '0;
          cmd_valid_reg <= 1'b0;
          state_reg     <= ARG;
        end else begin
          arg_reg       <= 32'd0;
          cmd_valid_reg <= 1'b1;
          state_reg     <= HOLD;
        end
      end
    end
  end

  assign bus.cmd       = cmd_reg;
  assign bus.arg       = arg_reg;
  assign bus.cmd_valid = cmd_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.overrun   = overrun_reg;

endmodule

// File: doc/debug_cmd_parser.md
Name: debug_cmd_parser

Overview:
- Front end of the debug controller. Converts the raw byte stream from the serial receiver into framed debug commands.
- Each command is one opcode byte plus an optional hex-encoded argument.
- Output is one command/argument pair at a time, on a valid/ready handshake, to the debug sequencer downstream.
- Generates the 8'hFF "serial read timeout" pseudo-command, which the sequencer treats as a NOP.

Parameters:
- TIMEOUT_CYCLES, 100000: idle cycles with no received byte before a timeout is reported; 0 disables timeouts.
- MAX_DIGITS, 8: maximum hex digits per argument; arguments are at most 32 bits.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte from the serial receiver.
- rx_valid  input  1  single-cycle strobe; rx_data is valid this cycle. There is no backpressure.
- cmd  output  8  command opcode (ASCII character, or 8'hFF for timeout).
- arg  output  32  parsed argument, zero-extended; 0 for commands that take no argument.
- cmd_valid  output  1  cmd/arg held stable while high.
- cmd_ready  input  1  sequencer accepts the command.
- frame_err  output  1  one-cycle pulse: the frame was malformed and discarded.
- overrun  output  1  one-cycle pulse: a byte was dropped while a command was pending.

Behaviour:
- Reset: state = IDLE. cmd = 0, arg = 0, cmd_valid = 0, frame_err = 0, overrun = 0. Digit counter = 0. Timeout counter = 0.
- States:
  - IDLE: waiting for an opcode.
  - ARG: accumulating hex digits.
  - HOLD: cmd_valid = 1, waiting for the handshake.
- IDLE, on rx_valid:
  - Bytes 0x0D, 0x0A, 0x20 are ignored.
  - Opcode in {'A','B','O','M','r'}: latch cmd, clear the accumulator and digit count, go to ARG.
  - Any other byte: latch cmd, arg = 0, go to HOLD. cmd_valid rises the cycle after the byte arrives (latency 1).
- ARG, on rx_valid:
  - Hex digit (0-9, A-F, a-f): accumulator = {acc[27:0], nibble}; digit count increments.
  - A digit arriving when the count already equals MAX_DIGITS: frame_err pulse, go to IDLE.
  - 0x0A or 0x0D with count >= 1: arg = accumulator, go to HOLD (cmd_valid rises the next cycle).
  - 0x0A or 0x0D with count = 0: frame_err, go to IDLE.
  - Any other byte: frame_err, go to IDLE.
- Argument width: the value is not truncated per command. The sequencer uses the low 16 bits for 'A' and the low 8 bits for 'B'.
- HOLD:
  - cmd and arg are stable until the handshake.
  - cmd_valid && cmd_ready: transfer completes, cmd_valid falls the next cycle, go to IDLE.
  - rx_valid in the same cycle as the handshake: the byte is processed with IDLE rules in that cycle. It is not lost.
  - rx_valid without cmd_ready: the byte is dropped and overrun pulses. State and outputs are unchanged.
- Timeout counter:
  - Increments each cycle in IDLE or ARG while rx_valid = 0.
  - Cleared by any rx_valid and by entering IDLE from HOLD.
  - Frozen at 0 in HOLD.
  - Reaching TIMEOUT_CYCLES in IDLE: cmd = 8'hFF, arg = 0, go to HOLD, counter cleared.
  - Reaching TIMEOUT_CYCLES in ARG: frame_err, go to IDLE, counter cleared.
- frame_err and overrun are never high in the same cycle they could conflict. A dropped byte in HOLD only raises overrun.
- rst asserted mid-frame or in HOLD: immediate return to reset values. A pending command is discarded without the handshake.

Test Plan:
- Bytes 'A','1','f','0','0',0x0A, cmd_ready held high -> one transfer: cmd = 0x41, arg = 0x00001F00. cmd_valid is high for exactly 1 cycle, the cycle after the 0x0A byte.
- Bytes 'T', then cmd_ready low for 5 cycles with 'c' arriving on cycle 3 -> cmd = 0x54, arg = 0 held for 5 cycles. overrun pulses once. After ready, the next cmd_valid appears only when a new byte arrives.
- 'M' then 9 hex digits '123456789' -> frame_err on the 9th digit, no cmd_valid. The following 'I' yields cmd = 0x49.
- 'B',0x0A -> frame_err. Then 'B','g' -> frame_err. Then 'B','7','F',0x0D -> cmd = 0x42, arg = 0x7F.
- TIMEOUT_CYCLES = 10, no input, ready high -> cmd = 0xFF, arg = 0 every 11 cycles (10 idle + 1 HOLD). Same setup with 'O','3' then silence -> frame_err after 10 idle cycles, no 0x4F command.
- Handshake completes in the same cycle 'N' arrives -> the next cycle presents cmd = 0x4E with no overrun. Asserting rst during 'A','1','2' -> outputs are zero, then 'R' -> cmd = 0x52, arg = 0.
